// File: rtl/ber_checker_if.sv
// Symbol-stream interface of the BER checker: reference/received bit strobes
// flowing in, lock status and error statistics flowing out.
interface ber_checker_if #(
    parameter int BUF_LEN = 512,
    parameter int NB_CNT  = 64
);
    logic                       i_enable;
    logic                       i_valid;
    logic                       i_ref_bit;
    logic                       i_rx_bit;
    logic                       o_locked;
    logic [$clog2(BUF_LEN)-1:0] o_latency;
    logic [NB_CNT-1:0]          o_bit_count;
    logic [NB_CNT-1:0]          o_err_count;

    // Stimulus side: drives the bit streams, observes the statistics
    modport master (
        output i_enable, i_valid, i_ref_bit, i_rx_bit,
        input  o_locked, o_latency, o_bit_count, o_err_count
    );

    // Checker side
    modport slave (
        input  i_enable, i_valid, i_ref_bit, i_rx_bit,
        output o_locked, o_latency, o_bit_count, o_err_count
    );
endinterface

// File: rtl/ber_checker.sv
// PRBS bit-error-rate checker. Searches every candidate latency between the
// reference stream and the received stream one window at a time, locks on the
// first error-free window (or on the best window after a full sweep), then
// counts compared bits and errors and drops lock when a window gets too noisy.
module ber_checker #(
    parameter int BUF_LEN  = 512,
    parameter int WIN_LEN  = 128,
    parameter int LOSS_THR = 32,
    parameter int NB_CNT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    ber_checker_if.slave bus
);
    localparam int LAT_W  = $clog2(BUF_LEN);
    localparam int FILL_W = LAT_W + 1;
    localparam int WCNT_W = $clog2(WIN_LEN);
    localparam int ERR_W  = $clog2(WIN_LEN) + 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state, state_next;

    // Reference history ring; entries not yet written since reset read as 0
    // through the fill gate below, so the array itself needs no clearing.
    logic              mem [BUF_LEN];
    logic [LAT_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;

    logic [LAT_W-1:0]  cand;
    logic [LAT_W-1:0]  best_lat;
    logic [LAT_W-1:0]  lat;
    logic [ERR_W-1:0]  min_err;
    logic [WCNT_W-1:0] win_cnt;
    logic [ERR_W-1:0]  win_err;
    logic [NB_CNT-1:0] bit_cnt;
    logic [NB_CNT-1:0] err_cnt;

    logic              strobe;
    logic [LAT_W-1:0]  cur_lat;
    logic [LAT_W-1:0]  rd_addr;
    logic              ref_sel;
    logic              e;
    logic              win_end;
    logic [ERR_W-1:0]  tot;
    logic              lock_now;
    logic [LAT_W-1:0]  lock_lat;
    logic              take_best;
    logic              lose;

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] c,
                                                  input logic inc);
        if (inc && (c != {NB_CNT{1'b1}}))
            return c + NB_CNT'(1);
        return c;
    endfunction

    assign strobe = bus.i_valid & bus.i_enable;

    // Reference selection and per-symbol error for the latency in use
    always_comb begin
        cur_lat = (state == LOCKED) ? lat : cand;
        rd_addr = wr_ptr - cur_lat;
        ref_sel = 1'b0;
        if (cur_lat == '0)
            ref_sel = bus.i_ref_bit;
        else if ({1'b0, cur_lat} <= fill)
            ref_sel = mem[rd_addr];
        e       = bus.i_rx_bit ^ ref_sel;
        win_end = (win_cnt == WCNT_W'(WIN_LEN - 1));
        tot     = win_err + {{(ERR_W-1){1'b0}}, e};
    end

    // Next-state and window-end decisions
    always_comb begin
        state_next = state;
        lock_now   = 1'b0;
        lock_lat   = lat;
        take_best  = 1'b0;
        lose       = 1'b0;
        if (strobe && win_end) begin
            case (state)
                SEARCH: begin
                    if (tot == '0) begin
                        state_next = LOCKED;
                        lock_now   = 1'b1;
                        lock_lat   = cand;
                    end else begin
                        // strict compare: ties keep the earlier (lower) candidate
                        take_best = (tot < min_err);
                        if (cand == LAT_W'(BUF_LEN - 1)) begin
                            state_next = LOCKED;
                            lock_now   = 1'b1;
                            lock_lat   = take_best ? cand : best_lat;
                        end
                    end
                end
                LOCKED: begin
                    if (tot >= ERR_W'(LOSS_THR)) begin
                        state_next = SEARCH;
                        lose       = 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= SEARCH;
        else
            state <= state_next;
    end

    // Reference history write; read above sees the pre-write contents
    always_ff @(posedge clk) begin
        if (strobe)
            mem[wr_ptr] <= bus.i_ref_bit;
    end

    // Window accounting, candidate sweep and locked statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill     <= '0;
            cand     <= '0;
            best_lat <= '0;
            lat      <= '0;
            min_err  <= '1;
            win_cnt  <= '0;
            win_err  <= '0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
        end else if (strobe) begin
            wr_ptr <= wr_ptr + LAT_W'(1);
            if (fill != FILL_W'(BUF_LEN))
                fill <= fill + FILL_W'(1);

            if (win_end) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_cnt + WCNT_W'(1);
                win_err <= tot;
            end

            if (state == SEARCH) begin
                if (take_best) begin
                    min_err  <= tot;
                    best_lat <= cand;
                end
                if (lock_now) begin
                    lat     <= lock_lat;
                    bit_cnt <= '0;
                    err_cnt <= '0;
                end else if (win_end) begin
                    cand <= cand + LAT_W'(1);
                end
            end else begin
                bit_cnt <= sat_inc(bit_cnt, 1'b1);
                err_cnt <= sat_inc(err_cnt, e);
                if (lose) begin
                    cand    <= '0;
                    min_err <= '1;
                end
            end
        end
    end

    assign bus.o_locked    = (state == LOCKED);
    assign bus.o_latency   = (state == LOCKED) ? lat : cand;
    assign bus.o_bit_count = bit_cnt;
    assign bus.o_err_count = err_cnt;
endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: PRBS9 reference stream, received stream built as a
// delayed copy with injected errors, outputs compared every cycle against a
// history-array model plus directed checks on lock timing and counters.
module tb_ber_checker;
    localparam int BUF_LEN  = 512;
    localparam int WIN_LEN  = 128;
    localparam int LOSS_THR = 32;
    localparam int NB_CNT   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ber_checker_if #(.BUF_LEN(BUF_LEN), .NB_CNT(NB_CNT)) bus ();

    ber_checker #(
        .BUF_LEN(BUF_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .NB_CNT(NB_CNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model state
    bit              m_hist[$];
    bit              m_locked;
    int              m_lat, m_cand, m_best, m_min, m_wcnt, m_werr;
    longint unsigned m_bits, m_errs;

    // stimulus generator state
    bit [8:0] lfsr;
    bit       gen_q[$];
    int       delay;
    int       sc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit prbs_next();
        bit b;
        b = lfsr[8] ^ lfsr[4];
        lfsr = {lfsr[7:0], b};
        return b;
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        m_locked = 0; m_lat = 0; m_cand = 0; m_best = 0;
        m_min = 1 << 30; m_wcnt = 0; m_werr = 0; m_bits = 0; m_errs = 0;
    endfunction

    function automatic void model_lock(input int l);
        m_locked = 1; m_lat = l; m_bits = 0; m_errs = 0;
    endfunction

    function automatic void model_step(input bit rb, input bit xb);
        int k, l, tot;
        bit r, err;
        k = m_hist.size();
        l = m_locked ? m_lat : m_cand;
        if (l == 0)          r = rb;
        else if (k - l >= 0) r = m_hist[k - l];
        else                 r = 1'b0;
        m_hist.push_back(rb);
        err = xb ^ r;
        if (m_locked) begin
            if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits++;
            if (err && m_errs != 64'hFFFF_FFFF_FFFF_FFFF) m_errs++;
        end
        m_wcnt++;
        m_werr += int'(err);
        if (m_wcnt == WIN_LEN) begin
            tot = m_werr;
            m_wcnt = 0;
            m_werr = 0;
            if (!m_locked) begin
                if (tot == 0) model_lock(m_cand);
                else begin
                    if (tot < m_min) begin m_min = tot; m_best = m_cand; end
                    if (m_cand == BUF_LEN - 1) model_lock(m_best);
                    else m_cand++;
                end
            end else if (tot >= LOSS_THR) begin
                m_locked = 0; m_cand = 0; m_min = 1 << 30;
            end
        end
    endfunction

    task automatic check_model();
        chk("locked",  64'(bus.o_locked),  64'(m_locked));
        chk("latency", 64'(bus.o_latency), 64'(m_locked ? m_lat : m_cand));
        chk("bits",    bus.o_bit_count,    m_bits);
        chk("errs",    bus.o_err_count,    m_errs);
    endtask

    // one clock: drive at negedge, model on posedge, compare at next negedge
    task automatic cyc(input bit v, input bit en, input bit flip);
        bit rb, xb;
        int n;
        if (v && en) begin
            rb = prbs_next();
            gen_q.push_back(rb);
            n = gen_q.size() - 1 - delay;
            xb = ((n >= 0) ? gen_q[n] : 1'b0) ^ flip;
        end else begin
            rb = 1'($urandom);
            xb = 1'($urandom);
        end
        bus.i_valid = v; bus.i_enable = en; bus.i_ref_bit = rb; bus.i_rx_bit = xb;
        @(posedge clk);
        if (v && en) begin
            model_step(rb, xb);
            sc++;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = 1'b1; bus.i_enable = 1'b1;
        bus.i_ref_bit = 1'($urandom); bus.i_rx_bit = 1'($urandom);
        @(posedge clk);
        model_reset();
        gen_q.delete();
        sc = 0;
        @(negedge clk);
        chk("rst_locked",  64'(bus.o_locked),  64'd0);
        chk("rst_latency", 64'(bus.o_latency), 64'd0);
        chk("rst_bits",    bus.o_bit_count,    64'd0);
        chk("rst_errs",    bus.o_err_count,    64'd0);
        rst = 1'b0;
    endtask

    initial begin
        longint unsigned b0, e0;
        int lock_sc, guard, ph;
        lfsr  = 9'(($urandom % 511) + 1);
        delay = 5;
        bus.i_valid = 0; bus.i_enable = 0; bus.i_ref_bit = 0; bus.i_rx_bit = 0;
        @(negedge clk);
        do_reset();

        // latency 5, error-free: early exit at candidate 5
        guard = 0;
        while (!bus.o_locked && guard < 2000) begin cyc(1, 1, 0); guard++; end
        lock_sc = sc;
        chk("lock5_seen",    64'(bus.o_locked),  64'd1);
        chk("lock5_strobe",  64'(lock_sc),       64'd768);
        chk("lock5_latency", 64'(bus.o_latency), 64'd5);
        for (int i = 0; i < 1000; i++) cyc(1, 1, 0);
        chk("run1000_bits", bus.o_bit_count, 64'd1000);
        chk("run1000_errs", bus.o_err_count, 64'd0);

        // random gaps and sparse random errors while locked
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom % 3 != 0), 1'($urandom % 5 != 0), 1'($urandom % 32 == 0));

        // single flipped bit
        e0 = bus.o_err_count;
        cyc(1, 1, 1);
        chk("single_err",    bus.o_err_count,   e0 + 1);
        chk("single_locked", 64'(bus.o_locked), 64'd1);

        // loss of lock: align to a window start, then invert a whole window
        guard = 0;
        while (m_wcnt != 0 && guard < WIN_LEN) begin cyc(1, 1, 0); guard++; end
        b0 = bus.o_bit_count;
        e0 = bus.o_err_count;
        for (int i = 0; i < WIN_LEN; i++) begin
            cyc(1, 1, 1);
            if (i == WIN_LEN - 2) chk("loss_still_locked", 64'(bus.o_locked), 64'd1);
        end
        chk("loss_unlocked", 64'(bus.o_locked),  64'd0);
        chk("loss_latency",  64'(bus.o_latency), 64'd0);
        chk("loss_bits",     bus.o_bit_count,    b0 + WIN_LEN);
        chk("loss_errs",     bus.o_err_count,    e0 + WIN_LEN);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0);
        chk("loss_bits_hold", bus.o_bit_count, b0 + WIN_LEN);

        // relock on the restored latency-5 stream
        lock_sc = sc;
        guard = 0;
        while (!bus.o_locked && guard < 2000) begin cyc(1, 1, 0); guard++; end
        chk("relock_seen",    64'(bus.o_locked),    64'd1);
        chk("relock_strobes", 64'(sc - lock_sc),    64'd758);
        chk("relock_latency", 64'(bus.o_latency),   64'd5);
        chk("relock_bits",    bus.o_bit_count,      64'd0);
        chk("relock_errs",    bus.o_err_count,      64'd0);
        for (int i = 0; i < 50; i++) cyc(1, 1, 0);

        // reset while locked
        do_reset();

        // sparse strobes, latency 2, enable dropped for 10 cycles
        delay = 2;
        ph = 0;
        guard = 0;
        while (!bus.o_locked && guard < 3000) begin
            cyc(ph % 4 == 0, !(ph >= 200 && ph < 210), 0);
            ph++; guard++;
        end
        chk("sparse_seen",    64'(bus.o_locked),  64'd1);
        chk("sparse_strobes", 64'(sc),            64'd384);
        chk("sparse_latency", 64'(bus.o_latency), 64'd2);
        for (int i = 0; i < 40; i++) begin
            cyc(ph % 4 == 0, !(i >= 10 && i < 20), 0);
            ph++;
        end
        chk("sparse_bits", bus.o_bit_count, 64'(sc - 384));

        // full sweep: latency 300 with two errors per window
        do_reset();
        delay = 300;
        guard = 0;
        while (!bus.o_locked && guard < 66000) begin
            cyc(1, 1, sc % 64 == 0);
            guard++;
        end
        chk("sweep_seen",    64'(bus.o_locked),  64'd1);
        chk("sweep_strobes", 64'(sc),            64'(BUF_LEN * WIN_LEN));
        chk("sweep_latency", 64'(bus.o_latency), 64'd300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
